fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: RESET_PC, 64'h0, fetch address loaded at reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_addr  output  64  fetch address; equals internal pc.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_rsp_valid  input  1  instruction word returned; in order; at most one outstanding.
REQ-008 imem_rsp_data  input  32  returned instruction word.
REQ-009 redirect_valid  input  1  branch/exception redirect from execute.
REQ-010 redirect_pc  input  64  redirect target.
REQ-011 inst_valid  output  1  buffered instruction available to decode.
REQ-012 inst_out  output  32  buffered instruction word.
REQ-013 inst_pc  output  64  address of inst_out.
REQ-014 inst_ready  input  1  decode consumes instruction this cycle.
REQ-015 fault  output  1  sticky misaligned-redirect flag (tied 0 when macro absent).

Function
REQ-016 FSM states SHALL be REQ, WAIT, HOLD, DROP, HALT; at most one memory request outstanding.
REQ-017 REQ: imem_req_valid=1, addr=pc; addr stable while valid&&!ready except on redirect; on ready -> WAIT.
REQ-018 WAIT: on imem_rsp_valid capture word into buffer, next cycle inst_valid=1, inst_pc=pc, -> HOLD.
REQ-019 HOLD: inst_valid/inst_out/inst_pc held stable until inst_ready; on inst_ready pc<=pc+4, -> REQ, inst_valid=0 next cycle.
REQ-020 Minimum latency: request accepted cycle N, response cycle N+k -> inst_valid cycle N+k+1.
REQ-021 pc increment SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 0).
REQ-022 Redirect has priority over all other events in every state except HALT.
REQ-023 Redirect in REQ, not accepted: pc<=redirect_pc, stay REQ, new address next cycle.
REQ-024 Redirect in REQ with imem_req_ready same cycle: pc<=redirect_pc, -> DROP.
REQ-025 Redirect in WAIT: pc<=redirect_pc; if imem_rsp_valid same cycle discard word, -> REQ; else -> DROP.
REQ-026 Redirect in HOLD (with or without inst_ready): inst_valid=0 next cycle, pc<=redirect_pc (not pc+4), -> REQ.
REQ-027 DROP: imem_req_valid=0; next imem_rsp_valid discarded, never presented, -> REQ.
REQ-028 imem_rsp_valid outside WAIT/DROP SHALL be ignored.

Reset
REQ-029 rst low SHALL immediately force: state REQ-pending, pc=RESET_PC, imem_req_valid=0, inst_valid=0, inst_out=0, inst_pc=0, fault=0.
REQ-030 First rising edge after rst high: enter REQ, imem_req_valid=1, addr=RESET_PC.
REQ-031 Reset mid-transaction: outstanding response after reset SHALL be ignored until REQ issues.

Configuration
REQ-032 Macro FETCH_ALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 sets fault=1 next cycle, -> HALT (no requests, inst_valid=0) until reset.
REQ-033 Macro absent: redirect_pc[1:0] forced to 2'b00, fault tied 0, HALT unreachable.

Verification
REQ-034 Reset release, ready=1, 1-cycle response -> addrs 0,4,8 issued; inst_pc 0,4,8 with matching words.
REQ-035 inst_ready low 5 cycles in HOLD -> inst_out/inst_pc stable, imem_req_valid=0, no pc advance.
REQ-036 Redirect to 0x1000 in WAIT, response next cycle -> word discarded, next request addr 0x1000.
REQ-037 Redirect to 0x2000 with inst_ready same cycle in HOLD -> next request 0x2000, not pc+4.
REQ-038 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second request address 0.
REQ-039 With FETCH_ALIGN_CHECK_EN, redirect to 0x1002 -> fault=1, no further imem_req_valid; rst low clears fault.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch sequencer with a
// one-entry instruction buffer toward decode.
// Optional feature: define FETCH_ALIGN_CHECK_EN to trap misaligned redirects
// (sticky fault, fetch halted until reset). Without the macro the low two
// redirect bits are dropped and fault is tied low.
//
// state | meaning
// ------+----------------------------------------------------------------
// REQ   | request at pc presented to memory (gated until first edge after reset)
// WAIT  | request accepted, waiting for the single outstanding response
// HOLD  | buffered instruction presented to decode, waiting for inst_ready
// DROP  | stale response still in flight; swallow it, then re-request
// HALT  | misaligned redirect seen; idle until reset
module fetch_sequencer #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [63:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [63:0] inst_pc,
   input  logic        inst_ready,
   output logic        fault
);

   localparam logic [2:0] ST_REQ  = 3'd0;
   localparam logic [2:0] ST_WAIT = 3'd1;
   localparam logic [2:0] ST_HOLD = 3'd2;
   localparam logic [2:0] ST_DROP = 3'd3;
   localparam logic [2:0] ST_HALT = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic        started_q;
   logic        capture;
   logic        redir_bad;
   logic [63:0] redir_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
   logic fault_q;

   assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign redir_tgt = redirect_pc;
   assign fault     = fault_q;

   // sticky fault, set on the edge that enters HALT
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         fault_q <= 1'b0;
      else if (state_q != ST_HALT && state_d == ST_HALT)
         fault_q <= 1'b1;
   end
`else
   logic unused_redir_lsb;

   assign unused_redir_lsb = ^redirect_pc[1:0];
   assign redir_bad        = 1'b0;
   assign redir_tgt        = {redirect_pc[63:2], 2'b00};
   assign fault            = 1'b0;
`endif

   assign imem_req_valid = started_q && (state_q == ST_REQ);
   assign imem_req_addr  = pc_q;
   assign inst_valid     = (state_q == ST_HOLD);

   // next-state and pc update; redirect outranks every other event
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      capture = 1'b0;
      if (started_q && state_q != ST_HALT) begin
         if (redir_bad) begin
            state_d = ST_HALT;
         end else if (redirect_valid) begin
            pc_d = redir_tgt;
            case (state_q)
               ST_REQ:  state_d = imem_req_ready ? ST_DROP : ST_REQ;
               ST_WAIT: state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
               ST_HOLD: state_d = ST_REQ;
               ST_DROP: state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
               default: state_d = state_q;
            endcase
         end else begin
            case (state_q)
               ST_REQ:
                  if (imem_req_ready) state_d = ST_WAIT;
               ST_WAIT:
                  if (imem_rsp_valid) begin
                     capture = 1'b1;
                     state_d = ST_HOLD;
                  end
               ST_HOLD:
                  if (inst_ready) begin
                     pc_d    = pc_q + 64'd4;
                     state_d = ST_REQ;
                  end
               ST_DROP:
                  if (imem_rsp_valid) state_d = ST_REQ;
               default: state_d = state_q;
            endcase
         end
      end
   end

   // control state; started_q holds off the first request for one edge after reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_REQ;
         pc_q      <= RESET_PC;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         started_q <= 1'b1;
      end
   end

   // one-entry instruction buffer toward decode
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_out <= 32'h0;
         inst_pc  <= 64'h0;
      end else if (capture) begin
         inst_out <= imem_rsp_data;
         inst_pc  <= pc_q;
      end
   end

endmodule
